memory_access: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline, between the EX/MEM and MEM/WB boundaries.
- Drives the data-memory interface (address, store data, access size, read/write enables) combinationally from EX-stage signals.
- Sign/zero-extends returned load data per funct3.
- Registers the writeback controls and data into the MEM/WB outputs (o_ma_*).

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/memory_access_load_extend.sv | 38 +++
 rtl/memory_access.sv | 109 ++++++++++
 tb/tb_memory_access.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the pipeline datapath:
//   - datapath and register-index widths
//   - funct3 encodings for loads and stores
//   - data-memory access-size encodings driven on o_data_rd_en_ctrl
//   - helper that maps a funct3 onto an access size
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size seen by the data memory
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } access_size_e;

    // The low two funct3 bits already carry the size for every legal
    // load/store; the unused code 11 is folded onto a word access so the
    // memory never sees an undefined size.
    function automatic access_size_e size_from_funct3(input logic [2:0] funct3);
        access_size_e size;
        case (funct3[1:0])
            2'b00:   size = SIZE_BYTE;
            2'b01:   size = SIZE_HALF;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Purely combinational load-data extension for the MEM stage.
// Ports:
//   funct3    in   3           load size / signedness
//   data_in   in   DATA_WIDTH  right-justified raw word from memory
//   data_out  out  DATA_WIDTH  sign/zero-extended load value
// Reserved funct3 codes (011, 110, 111) return the full word.
// ---------------------------------------------------------------------------
module load_extend
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = data_in[7:0];
    assign half_s = data_in[15:0];

    always_comb begin
        data_out = data_in;
        case (funct3)
            F3_LB:   data_out = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            F3_LH:   data_out = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            F3_LW:   data_out = data_in;
            F3_LBU:  data_out = {{(DATA_WIDTH-8){1'b0}}, data_in[7:0]};
            F3_LHU:  data_out = {{(DATA_WIDTH-16){1'b0}}, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
// MEM stage of the 5-stage RV32I pipeline.
//   - Drives the data-memory interface combinationally from EX/MEM signals.
//   - Extends returned load data according to funct3.
//   - Registers writeback controls and data into the MEM/WB outputs.
// Ports:
//   i_clk, i_rst_n (synchronous, active-high), i_clk_en (0 = stall)
//   i_data_rd              raw load data from memory (same cycle as address)
//   i_ex_*                 EX/MEM pipeline signals
//   o_data_wr/addr         store data and address to memory
//   o_data_rd_en_ctrl      access size (00 byte, 01 half, 10 word)
//   o_data_rd_en_ma/wr_en  memory read / write enables
//   o_ma_*                 MEM/WB pipeline register outputs
// i_ex_funct7 is reserved and has no effect.
// ---------------------------------------------------------------------------
module memory_access
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = riscv_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clk_en,
    input  logic [DATA_WIDTH-1:0]     i_data_rd,
    input  logic                      i_ex_mem_to_reg,
    input  logic [1:0]                i_ex_rw_sel,
    input  logic                      i_ex_reg_wr,
    input  logic                      i_ex_mem_rd,
    input  logic                      i_ex_mem_wr,
    input  logic [DATA_WIDTH-1:0]     i_ex_pc_plus_4,
    input  logic [DATA_WIDTH-1:0]     i_ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_ex_reg_read_data2,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_reg_dest,
    input  logic [2:0]                i_ex_funct3,
    input  logic [6:0]                i_ex_funct7,
    output logic [DATA_WIDTH-1:0]     o_data_wr,
    output logic [DATA_WIDTH-1:0]     o_data_addr,
    output logic [1:0]                o_data_rd_en_ctrl,
    output logic                      o_data_rd_en_ma,
    output logic                      o_data_wr_en_ma,
    output logic                      o_ma_mem_to_reg,
    output logic [1:0]                o_ma_rw_sel,
    output logic [DATA_WIDTH-1:0]     o_ma_pc_plus_4,
    output logic [DATA_WIDTH-1:0]     o_ma_read_data,
    output logic [DATA_WIDTH-1:0]     o_ma_result,
    output logic [REG_ADDR_WIDTH-1:0] o_ma_reg_dest,
    output logic                      o_ma_reg_wr
);

    // ---- p0: memory interface and load extension (combinational) ----
    logic [DATA_WIDTH-1:0] load_ext_p0;
    logic                  unused_funct7;

    assign unused_funct7 = ^i_ex_funct7;

    assign o_data_addr       = i_ex_alu_result;
    assign o_data_wr         = i_ex_reg_read_data2;
    assign o_data_rd_en_ctrl = size_from_funct3(i_ex_funct3);
    assign o_data_rd_en_ma   = i_ex_mem_rd;
    assign o_data_wr_en_ma   = i_ex_mem_wr;

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .funct3   (i_ex_funct3),
        .data_in  (i_data_rd),
        .data_out (load_ext_p0)
    );

    // ---- p1: MEM/WB pipeline register ----
    logic                      mem_to_reg_p1;
    logic [1:0]                rw_sel_p1;
    logic [DATA_WIDTH-1:0]     pc_plus_4_p1;
    logic [DATA_WIDTH-1:0]     read_data_p1;
    logic [DATA_WIDTH-1:0]     result_p1;
    logic [REG_ADDR_WIDTH-1:0] reg_dest_p1;
    logic                      reg_wr_p1;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            mem_to_reg_p1 <= 1'b0;
            rw_sel_p1     <= '0;
            pc_plus_4_p1  <= '0;
            read_data_p1  <= '0;
            result_p1     <= '0;
            reg_dest_p1   <= '0;
            reg_wr_p1     <= 1'b0;
        end else if (i_clk_en) begin
            mem_to_reg_p1 <= i_ex_mem_to_reg;
            rw_sel_p1     <= i_ex_rw_sel;
            pc_plus_4_p1  <= i_ex_pc_plus_4;
            read_data_p1  <= load_ext_p0;
            result_p1     <= i_ex_alu_result;
            reg_dest_p1   <= i_ex_reg_dest;
            reg_wr_p1     <= i_ex_reg_wr;
        end
    end

    assign o_ma_mem_to_reg = mem_to_reg_p1;
    assign o_ma_rw_sel     = rw_sel_p1;
    assign o_ma_pc_plus_4  = pc_plus_4_p1;
    assign o_ma_read_data  = read_data_p1;
    assign o_ma_result     = result_p1;
    assign o_ma_reg_dest   = reg_dest_p1;
    assign o_ma_reg_wr     = reg_wr_p1;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_clk_en = 1'b0;
    logic [31:0] i_data_rd = '0;
    logic        i_ex_mem_to_reg = 1'b0;
    logic [1:0]  i_ex_rw_sel = '0;
    logic        i_ex_reg_wr = 1'b0;
    logic        i_ex_mem_rd = 1'b0;
    logic        i_ex_mem_wr = 1'b0;
    logic [31:0] i_ex_pc_plus_4 = '0;
    logic [31:0] i_ex_alu_result = '0;
    logic [31:0] i_ex_reg_read_data2 = '0;
    logic [4:0]  i_ex_reg_dest = '0;
    logic [2:0]  i_ex_funct3 = '0;
    logic [6:0]  i_ex_funct7 = '0;

    logic [31:0] o_data_wr, o_data_addr;
    logic [1:0]  o_data_rd_en_ctrl;
    logic        o_data_rd_en_ma, o_data_wr_en_ma;
    logic        o_ma_mem_to_reg;
    logic [1:0]  o_ma_rw_sel;
    logic [31:0] o_ma_pc_plus_4, o_ma_read_data, o_ma_result;
    logic [4:0]  o_ma_reg_dest;
    logic        o_ma_reg_wr;

    memory_access dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_clk_en            (i_clk_en),
        .i_data_rd           (i_data_rd),
        .i_ex_mem_to_reg     (i_ex_mem_to_reg),
        .i_ex_rw_sel         (i_ex_rw_sel),
        .i_ex_reg_wr         (i_ex_reg_wr),
        .i_ex_mem_rd         (i_ex_mem_rd),
        .i_ex_mem_wr         (i_ex_mem_wr),
        .i_ex_pc_plus_4      (i_ex_pc_plus_4),
        .i_ex_alu_result     (i_ex_alu_result),
        .i_ex_reg_read_data2 (i_ex_reg_read_data2),
        .i_ex_reg_dest       (i_ex_reg_dest),
        .i_ex_funct3         (i_ex_funct3),
        .i_ex_funct7         (i_ex_funct7),
        .o_data_wr           (o_data_wr),
        .o_data_addr         (o_data_addr),
        .o_data_rd_en_ctrl   (o_data_rd_en_ctrl),
        .o_data_rd_en_ma     (o_data_rd_en_ma),
        .o_data_wr_en_ma     (o_data_wr_en_ma),
        .o_ma_mem_to_reg     (o_ma_mem_to_reg),
        .o_ma_rw_sel         (o_ma_rw_sel),
        .o_ma_pc_plus_4      (o_ma_pc_plus_4),
        .o_ma_read_data      (o_ma_read_data),
        .o_ma_result         (o_ma_result),
        .o_ma_reg_dest       (o_ma_reg_dest),
        .o_ma_reg_wr         (o_ma_reg_wr)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference state of the MEM/WB register
    logic        exp_mem_to_reg = 1'b0;
    logic [1:0]  exp_rw_sel = '0;
    logic [31:0] exp_pc4 = '0, exp_rd_data = '0, exp_result = '0;
    logic [4:0]  exp_dest = '0;
    logic        exp_reg_wr = 1'b0;

    // Load value as the ISA defines it, via integer arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        case (f3)
            3'd0: begin v = d % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = d % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = d % 256;
            3'd5: v = d % 65536;
            default: v = d;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [1:0] ref_size(input logic [2:0] f3);
        int s;
        s = f3 % 4;
        if (s > 2) s = 2;
        return s[1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem_side();
        #1;
        check("addr",    o_data_addr, i_ex_alu_result);
        check("wdata",   o_data_wr, i_ex_reg_read_data2);
        check("size",    {30'd0, o_data_rd_en_ctrl}, {30'd0, ref_size(i_ex_funct3)});
        check("rd_en",   {31'd0, o_data_rd_en_ma}, {31'd0, i_ex_mem_rd});
        check("wr_en",   {31'd0, o_data_wr_en_ma}, {31'd0, i_ex_mem_wr});
    endtask

    // Advance one clock, updating the reference register first
    task automatic tick();
        if (i_rst_n) begin
            exp_mem_to_reg = 0; exp_rw_sel = 0; exp_pc4 = 0; exp_rd_data = 0;
            exp_result = 0; exp_dest = 0; exp_reg_wr = 0;
        end else if (i_clk_en) begin
            exp_mem_to_reg = i_ex_mem_to_reg;
            exp_rw_sel     = i_ex_rw_sel;
            exp_pc4        = i_ex_pc_plus_4;
            exp_rd_data    = ref_load(i_ex_funct3, i_data_rd);
            exp_result     = i_ex_alu_result;
            exp_dest       = i_ex_reg_dest;
            exp_reg_wr     = i_ex_reg_wr;
        end
        @(posedge i_clk);
        #1;
        check("ma_mem_to_reg", {31'd0, o_ma_mem_to_reg}, {31'd0, exp_mem_to_reg});
        check("ma_rw_sel",     {30'd0, o_ma_rw_sel}, {30'd0, exp_rw_sel});
        check("ma_pc4",        o_ma_pc_plus_4, exp_pc4);
        check("ma_read_data",  o_ma_read_data, exp_rd_data);
        check("ma_result",     o_ma_result, exp_result);
        check("ma_reg_dest",   {27'd0, o_ma_reg_dest}, {27'd0, exp_dest});
        check("ma_reg_wr",     {31'd0, o_ma_reg_wr}, {31'd0, exp_reg_wr});
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] d);
        i_ex_mem_rd = 1; i_ex_mem_wr = 0; i_ex_funct3 = f3; i_data_rd = d;
        i_ex_mem_to_reg = 1; i_ex_reg_wr = 1; i_ex_rw_sel = 2'd1;
        i_ex_alu_result = $urandom; i_ex_reg_dest = 5'($urandom);
        i_ex_funct7 = 7'($urandom);
        check_mem_side();
        tick();
    endtask

    task automatic randomize_inputs();
        i_data_rd           = $urandom;
        i_ex_mem_to_reg     = 1'($urandom);
        i_ex_rw_sel         = 2'($urandom);
        i_ex_reg_wr         = 1'($urandom);
        i_ex_mem_rd         = 1'($urandom);
        i_ex_mem_wr         = 1'($urandom);
        i_ex_pc_plus_4      = $urandom;
        i_ex_alu_result     = $urandom;
        i_ex_reg_read_data2 = $urandom;
        i_ex_reg_dest       = 5'($urandom);
        i_ex_funct3         = 3'($urandom);
        i_ex_funct7         = 7'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with nonzero inputs
        randomize_inputs();
        i_ex_reg_wr = 1; i_rst_n = 1; i_clk_en = 1;
        check_mem_side();
        tick();
        check("rst_reg_wr", {31'd0, o_ma_reg_wr}, 32'd0);
        check("rst_result", o_ma_result, 32'd0);

        // First instruction after reset release
        i_rst_n = 0; i_clk_en = 1;
        i_ex_reg_dest = 5'd10; i_ex_pc_plus_4 = 32'h4; i_ex_alu_result = 32'h10;
        check_mem_side();
        tick();
        check("first_dest",   {27'd0, o_ma_reg_dest}, 32'd10);
        check("first_pc4",    o_ma_pc_plus_4, 32'h4);
        check("first_result", o_ma_result, 32'h10);

        // Directed loads
        load(3'b000, 32'hFFFFFF80); check("lb_neg",  o_ma_read_data, 32'hFFFFFF80);
        load(3'b000, 32'h0000017F); check("lb_pos",  o_ma_read_data, 32'h0000007F);
        load(3'b001, 32'h00008000); check("lh_neg",  o_ma_read_data, 32'hFFFF8000);
        load(3'b010, 32'h12345678); check("lw",      o_ma_read_data, 32'h12345678);
        load(3'b100, 32'hFFFFFFAB); check("lbu",     o_ma_read_data, 32'h000000AB);
        load(3'b101, 32'hFFFFABCD); check("lhu",     o_ma_read_data, 32'h0000ABCD);
        load(3'b111, 32'h8000_00F0); check("f3_111", o_ma_read_data, 32'h800000F0);

        // Store word
        i_ex_mem_wr = 1; i_ex_mem_rd = 0; i_ex_reg_read_data2 = 32'hCAFEBABE;
        i_ex_alu_result = 32'h10000000; i_ex_funct3 = 3'b010; i_ex_reg_wr = 0;
        #1;
        check("sw_wdata", o_data_wr, 32'hCAFEBABE);
        check("sw_addr",  o_data_addr, 32'h10000000);
        check("sw_wr_en", {31'd0, o_data_wr_en_ma}, 32'd1);
        check("sw_rd_en", {31'd0, o_data_rd_en_ma}, 32'd0);
        check("sw_size",  {30'd0, o_data_rd_en_ctrl}, 32'd2);
        tick();

        // Size code 11 is folded to word
        i_ex_funct3 = 3'b011;
        #1;
        check("size_11", {30'd0, o_data_rd_en_ctrl}, 32'd2);

        // Stall: registered outputs hold, memory side tracks
        i_clk_en = 0;
        randomize_inputs();
        check_mem_side();
        tick();
        check("stall_result", o_ma_result, 32'h10000000);
        randomize_inputs();
        check_mem_side();
        tick();

        // Reset has priority over stall
        i_rst_n = 1; i_clk_en = 0;
        check_mem_side();
        tick();
        check("prio_reg_wr", {31'd0, o_ma_reg_wr}, 32'd0);
        check("prio_pc4",    o_ma_pc_plus_4, 32'd0);
        i_rst_n = 0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            i_clk_en = ($urandom_range(0, 3) != 0);
            i_rst_n  = ($urandom_range(0, 19) == 0);
            check_mem_side();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
